// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx between NUM_REQ byte requesters.
// Requesters are served round-robin. A multi-byte packet keeps the grant
// until its last byte has gone out. A transmitter that never raises busy
// is detected, flagged and skipped.
`timescale 1ns/1ps

module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int START_TIMEOUT = 15,
   localparam int GW           = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_send,
   input  logic                 tx_busy,
   output logic [GW-1:0]        grant,
   output logic                 locked,
   output logic                 err_timeout
);

   localparam int CW = $clog2(START_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ARB        = 2'd0,
      ISSUE      = 2'd1,
      WAIT_START = 2'd2,
      WAIT_DONE  = 2'd3
   } state_t;

   state_t          state_reg;
   logic [GW-1:0]   rr_ptr_reg;
   logic            last_reg;
   logic [CW-1:0]   count_reg;

   logic [7:0]      lane_data [NUM_REQ];
   logic            win_found;
   logic [GW-1:0]   win_idx;
   logic [GW-1:0]   cand;

   // Split the packed data bus into one byte lane per requester.
   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
      assign lane_data[gi] = req_data[8*gi +: 8];
   end

   // Index after i, wrapping from the last requester back to 0.
   function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] i);
      if (int'(i) == NUM_REQ - 1)
         return '0;
      else
         return i + GW'(1);
   endfunction

   // Pick the winner: the lock owner alone while locked, otherwise the first
   // valid requester at or after rr_ptr. Scanning from the far end lets the
   // nearest candidate overwrite the others.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      if (locked) begin
         win_found = req_valid[grant];
         win_idx   = grant;
      end else begin
         for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = GW'((int'(rr_ptr_reg) + k) % NUM_REQ);
            if (req_valid[cand]) begin
               win_found = 1'b1;
               win_idx   = cand;
            end
         end
      end
   end

   // Arbitration / transmit-handshake state machine with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ARB;
         rr_ptr_reg  <= '0;
         grant       <= '0;
         locked      <= 1'b0;
         last_reg    <= 1'b0;
         tx_data     <= 8'h00;
         tx_send     <= 1'b0;
         req_ready   <= '0;
         err_timeout <= 1'b0;
         count_reg   <= '0;
      end else begin
         // Strobes are single-cycle; only the ARB->ISSUE transition raises them.
         tx_send   <= 1'b0;
         req_ready <= '0;
         case (state_reg)
            ARB: begin
               if (win_found) begin
                  tx_data   <= lane_data[win_idx];
                  last_reg  <= req_last[win_idx];
                  grant     <= win_idx;
                  tx_send   <= 1'b1;
                  req_ready <= NUM_REQ'(1) << win_idx;
                  state_reg <= ISSUE;
               end
            end
            ISSUE: begin
               count_reg <= '0;
               state_reg <= WAIT_START;
            end
            WAIT_START: begin
               if (tx_busy) begin
                  state_reg <= WAIT_DONE;
               end else if (count_reg == CW'(START_TIMEOUT - 1)) begin
                  // Transmitter never started: flag it, drop any lock and move on.
                  count_reg   <= count_reg + CW'(1);
                  err_timeout <= 1'b1;
                  locked      <= 1'b0;
                  rr_ptr_reg  <= next_idx(grant);
                  state_reg   <= ARB;
               end else begin
                  count_reg <= count_reg + CW'(1);
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  state_reg <= ARB;
                  if (last_reg) begin
                     locked     <= 1'b0;
                     rr_ptr_reg <= next_idx(grant);
                  end else begin
                     locked <= 1'b1;
                  end
               end
            end
            default: state_reg <= ARB;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: requesters stream packets from
// per-requester byte stores, a simple uart_tx model answers each send with a
// random delay/busy length (or never, to provoke the start timeout), and a
// transaction-level model predicts every grant.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

   localparam int N  = 4;
   localparam int TO = 15;
   localparam int GW = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic [7:0]     tx_data;
   logic           tx_send;
   logic           tx_busy;
   logic [GW-1:0]  grant;
   logic           locked;
   logic           err_timeout;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(N), .START_TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_data     (tx_data),
      .tx_send     (tx_send),
      .tx_busy     (tx_busy),
      .grant       (grant),
      .locked      (locked),
      .err_timeout (err_timeout)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Per-requester byte store: {last, data}
   logic [8:0] pkt [N][64];
   int head [N];
   int tail [N];
   int total_bytes;

   // Transaction-level reference state
   int m_rr;
   bit m_locked;
   int m_owner;
   bit m_err;

   // uart_tx model: 0 idle, 1 start delay, 2 busy, 3 never starts
   int u_phase;
   int u_cnt;
   int u_len;
   bit u_err_before;
   int sends;
   int txn;

   task automatic random_cycle();
      int w;
      logic [N-1:0] v;
      logic [8:0] b;
      @(negedge clk);
      v = req_valid;   // what the DUT sampled at the preceding edge
      if (tx_send) begin
         sends++;
         check("send_while_uart_active", u_phase, 0);
         if (m_locked) begin
            w = v[m_owner] ? m_owner : -1;
         end else begin
            w = -1;
            for (int k = 0; k < N; k++)
               if (w < 0 && v[(m_rr + k) % N]) w = (m_rr + k) % N;
         end
         if (w < 0) begin
            check("ready_no_eligible", req_ready, 0);
         end else begin
            b = pkt[w][head[w]];
            check("ready", req_ready, N'(1) << w);
            check("tx_data", tx_data, b[7:0]);
            check("grant", grant, w);
            check("locked", locked, m_locked);
            check("err_timeout", err_timeout, m_err);
            $display("txn %0d: req %0d byte 0x%02h last %0d", txn, w, b[7:0], b[8]);
            head[w]++;
            req_valid[w] = 1'b0;
            if (txn == 3 || $urandom_range(0, 9) == 0) begin
               u_phase      = 3;
               u_cnt        = 0;
               u_err_before = m_err;
               m_err        = 1'b1;
               m_locked     = 1'b0;
               m_rr         = (w + 1) % N;
            end else begin
               u_phase = 1;
               u_cnt   = $urandom_range(1, 4);
               u_len   = $urandom_range(1, 8);
               if (b[8]) begin
                  m_locked = 1'b0;
                  m_rr     = (w + 1) % N;
               end else begin
                  m_locked = 1'b1;
                  m_owner  = w;
               end
            end
            txn++;
         end
      end else begin
         check("ready_without_send", req_ready, 0);
         case (u_phase)
            1: begin
               u_cnt--;
               if (u_cnt == 0) begin
                  tx_busy = 1'b1;
                  u_phase = 2;
                  u_cnt   = u_len;
               end
            end
            2: begin
               u_cnt--;
               if (u_cnt == 0) begin
                  tx_busy = 1'b0;
                  u_phase = 0;
               end
            end
            3: begin
               u_cnt++;
               if (u_cnt == TO) check("err_before_limit", err_timeout, u_err_before);
               if (u_cnt == TO + 1) begin
                  check("err_at_limit", err_timeout, 1);
                  u_phase = 0;
               end
            end
            default: ;
         endcase
      end
      // Requesters: offer the next stored byte at random, hold until ready.
      for (int i = 0; i < N; i++) begin
         if (!req_valid[i]) begin
            if (head[i] < tail[i] && $urandom_range(0, 1) == 1) begin
               req_valid[i]     = 1'b1;
               req_data[8*i +: 8] = pkt[i][head[i]][7:0];
               req_last[i]      = pkt[i][head[i]][8];
            end else begin
               req_data[8*i +: 8] = 8'($urandom);
               req_last[i]      = 1'($urandom);
            end
         end
      end
   endtask

   task automatic wait_send(output bit got);
      got = 1'b0;
      for (int c = 0; c < 50 && !got; c++) begin
         @(negedge clk);
         if (tx_send) got = 1'b1;
      end
   endtask

   initial begin
      bit got;
      int len;
      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      tx_busy   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx_send", tx_send, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_grant", grant, 0);
      check("rst_locked", locked, 0);
      check("rst_err", err_timeout, 0);
      reset = 1'b0;

      // Build random packets (1..3 bytes each, last flag on the final byte).
      total_bytes = 0;
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         tail[i] = 0;
         while (tail[i] < 10) begin
            len = $urandom_range(1, 3);
            for (int j = 0; j < len; j++) begin
               pkt[i][tail[i]] = {(j == len - 1), 8'($urandom)};
               tail[i]++;
            end
         end
         total_bytes += tail[i];
      end
      m_rr = 0; m_locked = 1'b0; m_owner = 0; m_err = 1'b0;
      u_phase = 0; u_cnt = 0; u_len = 0; u_err_before = 1'b0;
      sends = 0; txn = 0;

      for (int c = 0; c < 20000 && !(sends >= total_bytes && u_phase == 0); c++)
         random_cycle();
      repeat (30) random_cycle();
      check("bytes_sent", sends, total_bytes);

      // Reset during WAIT_DONE: one full byte from req2 (pointer moves to 3),
      // then a non-last byte from req3 interrupted by reset.
      req_valid = 4'b0100;
      req_data  = {8'h00, 8'hC3, 8'h00, 8'h00};
      req_last  = 4'b1111;
      wait_send(got);
      check("mid1_send_seen", got, 1);
      check("mid1_grant", grant, 2);
      check("mid1_data", tx_data, 8'hC3);
      req_valid = '0;
      @(negedge clk); tx_busy = 1'b1;
      @(negedge clk); tx_busy = 1'b0;
      req_valid = 4'b1000;
      req_data  = {8'h5A, 8'h00, 8'h00, 8'h00};
      req_last  = 4'b0000;
      wait_send(got);
      check("mid2_send_seen", got, 1);
      check("mid2_grant", grant, 3);
      req_valid = '0;
      @(negedge clk); tx_busy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      req_valid = 4'b1111;
      req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      req_last  = 4'b1111;
      reset     = 1'b1;
      @(negedge clk);
      check("midrst_tx_send", tx_send, 0);
      check("midrst_req_ready", req_ready, 0);
      check("midrst_tx_data", tx_data, 8'h00);
      check("midrst_grant", grant, 0);
      check("midrst_locked", locked, 0);
      check("midrst_err", err_timeout, 0);
      reset   = 1'b0;
      tx_busy = 1'b0;
      wait_send(got);
      check("post_rst_send_seen", got, 1);
      check("post_rst_ready", req_ready, 4'b0001);
      check("post_rst_grant", grant, 0);
      check("post_rst_data", tx_data, 8'hA0);
      $display("txn post-reset: req %0d byte 0x%02h", grant, tx_data);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one uart_tx; legal range 2..8.
REQ-002 Parameter START_TIMEOUT, default 15: maximum WAIT_START cycles before tx_busy must rise.
REQ-003 Localparam GW = max(1, clog2(NUM_REQ)): width of grant.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  NUM_REQ  bit i high = requester i offers a byte.
REQ-007 req_data  input  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
REQ-008 req_last  input  NUM_REQ  bit i high = offered byte ends requester i's packet.
REQ-009 req_ready  output  NUM_REQ  one-cycle pulse on bit i = byte of requester i accepted.
REQ-010 tx_data  output  8  byte presented to uart_tx data_in.
REQ-011 tx_send  output  1  one-cycle start pulse to uart_tx send.
REQ-012 tx_busy  input  1  uart_tx busy.
REQ-013 grant  output  GW  index of current/last granted requester.
REQ-014 locked  output  1  high while a multi-byte packet holds the grant.
REQ-015 err_timeout  output  1  sticky flag; tx_busy failed to rise within START_TIMEOUT.

Function
REQ-016 FSM states: ARB, ISSUE, WAIT_START, WAIT_DONE; all outputs registered.
REQ-017 ARB, locked=0: winner = first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ; no valid -> stay ARB.
REQ-018 ARB, locked=1: only requester grant is eligible; other requesters ignored regardless of req_valid; wait indefinitely.
REQ-019 On winner w: capture req_data[w] into tx_data, req_last[w] into last_r, grant<=w, go ISSUE.
REQ-020 ISSUE (exactly one cycle): tx_send=1 and req_ready[w]=1; all other cycles both 0; go WAIT_START, clear timeout counter.
REQ-021 Latency: req_valid sampled high in ARB -> tx_send and req_ready high the next cycle.
REQ-022 Requester holds req_valid/req_data/req_last stable until it sees req_ready; the cycle of req_ready is never re-sampled.
REQ-023 WAIT_START: tx_busy=1 -> WAIT_DONE; else increment counter; counter reaching START_TIMEOUT -> err_timeout<=1, locked<=0, rr_ptr<=grant+1 mod NUM_REQ, go ARB.
REQ-024 WAIT_DONE: remain while tx_busy=1; on tx_busy=0 go ARB.
REQ-025 Leaving WAIT_DONE with last_r=1: locked<=0, rr_ptr<=grant+1 mod NUM_REQ.
REQ-026 Leaving WAIT_DONE with last_r=0: locked<=1, rr_ptr unchanged.
REQ-027 tx_data holds its value from ISSUE until the next capture.
REQ-028 rr_ptr wraps NUM_REQ-1 -> 0.
REQ-029 err_timeout clears only on reset.

Reset
REQ-030 reset=1 on any edge, in any state: state<=ARB, rr_ptr<=0, grant<=0, locked<=0, last_r<=0, tx_data<=8'h00, tx_send<=0, req_ready<=0, err_timeout<=0, counter<=0.
REQ-031 Reset mid-transfer: no further tx_send until a fresh arbitration; uart_tx is reset by the same signal.

Verification
REQ-032 Single: reset, req_valid=4'b0001, data0=8'hA5, last0=1 -> next cycle tx_send=1, req_ready=4'b0001, tx_data=8'hA5; after busy falls rr_ptr=1.
REQ-033 Round-robin: all four valid, all last=1, uart_tx attached -> bytes sent in order requester 0,1,2,3,0; exactly one req_ready pulse per byte.
REQ-034 Packet lock: req1 sends 3 bytes (8'h10,8'h11,8'h12, last on third), req2 valid throughout -> no req2 byte until 8'h12 completes; locked=1 between bytes.
REQ-035 Timeout: tx_busy tied 0, req0 valid -> one tx_send, err_timeout=1 after 15 WAIT_START cycles, FSM back in ARB, rr_ptr=1.
REQ-036 Reset mid-frame: assert reset during WAIT_DONE -> next cycle all outputs at reset values, first grant afterwards to requester 0.
REQ-037 Wrap: only req3 valid repeatedly with last=1 -> each byte granted to 3, rr_ptr wraps to 0.
